// File: rtl/line_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// line_buffer_ctrl : ping-pong line buffer sequencer and single-port RAM arbiter
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module line_buffer_ctrl #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 8,
  parameter int LINE_LEN = 240
) (
  input  logic              VIDEO_CLK,
  input  logic              RESET,
  input  logic              WR_LINE_START,
  input  logic              WR_VALID,
  input  logic [DATA_W-1:0] WR_DATA,
  output logic              WR_READY,
  input  logic              RD_LINE_START,
  input  logic              RD_REQ,
  output logic              RD_VALID,
  output logic [DATA_W-1:0] RD_DATA,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic              RAM_WE,
  output logic [DATA_W-1:0] RAM_WDATA,
  input  logic [DATA_W-1:0] RAM_RDATA,
  output logic              LINE_READY,
  output logic              OVERRUN,
  output logic [7:0]        REPEAT_COUNT
);

  localparam int                PTR_W    = ADDR_W - 1;
  localparam logic [ADDR_W-1:0] C_LEN    = ADDR_W'(LINE_LEN);
  localparam logic [PTR_W-1:0]  C_LAST   = PTR_W'(LINE_LEN - 1);

  // Pointers are one bit wider than the pixel field so a full 2^PTR_W line
  // can be counted without wrapping; the write pointer is the low bits of wr_cnt.
  logic              wr_bank_q, wr_bank_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic              hold_full_q, hold_full_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic              wr_done_q, wr_done_d;
  logic              line_ready_q, line_ready_d;
  logic              overrun_q, overrun_d;
  logic [7:0]        repeat_q, repeat_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_hit_q, rd_hit_d;

  logic              swap;
  logic              rd_bank_eff;
  logic [ADDR_W-1:0] rd_ptr_eff;
  logic              rd_in_range;
  logic              drain;
  logic              accept;
  logic              load;
  logic [ADDR_W-1:0] wr_cnt_eff;

  always_comb begin
    swap        = RD_LINE_START & wr_done_q;
    rd_bank_eff = swap ? wr_bank_q : ~wr_bank_q;
    rd_ptr_eff  = RD_LINE_START ? '0 : rd_ptr_q;
    rd_in_range = (rd_ptr_eff < C_LEN);
    drain       = hold_full_q & ~RD_REQ & ~RESET;

    RAM_WE    = drain;
    RAM_WDATA = hold_data_q;
    RAM_ADDR  = drain ? hold_addr_q : {rd_bank_eff, rd_ptr_eff[PTR_W-1:0]};

    WR_READY   = ~hold_full_q;
    accept     = WR_VALID & ~hold_full_q;
    wr_cnt_eff = (WR_LINE_START & ~wr_done_q) ? '0 : wr_cnt_q;
    load       = accept & ~wr_done_q & (wr_cnt_eff < C_LEN);

    wr_cnt_d    = wr_cnt_eff + ADDR_W'(load);
    hold_full_d = load | (hold_full_q & ~drain);
    hold_addr_d = load ? {wr_bank_q, wr_cnt_eff[PTR_W-1:0]} : hold_addr_q;
    hold_data_d = load ? WR_DATA : hold_data_q;
    overrun_d   = overrun_q | (accept & ~load);

    // Done only once the last pixel has actually reached the RAM.
    wr_done_d    = wr_done_q | (drain & (hold_addr_q[PTR_W-1:0] == C_LAST));
    wr_bank_d    = wr_bank_q ^ swap;
    line_ready_d = line_ready_q | swap;
    repeat_d     = repeat_q;
    if (swap) begin
      wr_done_d = 1'b0;
      wr_cnt_d  = '0;
    end else if (RD_LINE_START && repeat_q != 8'hFF) begin
      repeat_d = repeat_q + 8'd1;
    end

    rd_ptr_d   = rd_ptr_eff + ADDR_W'(RD_REQ & rd_in_range);
    rd_valid_d = RD_REQ;
    rd_hit_d   = RD_REQ & rd_in_range;
  end

  always_ff @(posedge VIDEO_CLK) begin
    if (RESET) begin
      wr_bank_q    <= 1'b0;
      wr_cnt_q     <= '0;
      rd_ptr_q     <= '0;
      hold_full_q  <= 1'b0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      wr_done_q    <= 1'b0;
      line_ready_q <= 1'b0;
      overrun_q    <= 1'b0;
      repeat_q     <= '0;
      rd_valid_q   <= 1'b0;
      rd_hit_q     <= 1'b0;
    end else begin
      wr_bank_q    <= wr_bank_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_ptr_q     <= rd_ptr_d;
      hold_full_q  <= hold_full_d;
      hold_addr_q  <= hold_addr_d;
      hold_data_q  <= hold_data_d;
      wr_done_q    <= wr_done_d;
      line_ready_q <= line_ready_d;
      overrun_q    <= overrun_d;
      repeat_q     <= repeat_d;
      rd_valid_q   <= rd_valid_d;
      rd_hit_q     <= rd_hit_d;
    end
  end

  assign RD_VALID     = rd_valid_q;
  assign RD_DATA      = rd_hit_q ? RAM_RDATA : '0;
  assign LINE_READY   = line_ready_q;
  assign OVERRUN      = overrun_q;
  assign REPEAT_COUNT = repeat_q;

endmodule

`default_nettype wire

// File: doc/line_buffer_ctrl.md
# line_buffer_ctrl

Sequencer and arbiter for the single-port line buffer RAM between the capture path and the VGA output path, all on `VIDEO_CLK`. The RAM is split into two banks (ping-pong). Capture fills the write bank while `vga_control` reads the read bank, and the banks swap at display line start once a full capture line has landed. Each cycle the block grants the one RAM port to either the display read or a buffered capture write, with reads taking priority.

## Interface
Parameters:
- `ADDR_W`, default 9: RAM address width. The MSB is the bank select; the lower `ADDR_W-1` bits are the pixel pointer.
- `DATA_W`, default 8: pixel width.
- `LINE_LEN`, default 240: pixels per line. Must satisfy `LINE_LEN <= 2^(ADDR_W-1)`.

Ports:
- `VIDEO_CLK`, in, 1: the only clock.
- `RESET`, in, 1: synchronous, active-high.
- `WR_LINE_START`, in, 1: one-cycle pulse marking the start of a capture line.
- `WR_VALID`, in, 1: capture pixel valid.
- `WR_DATA`, in, `DATA_W`: capture pixel.
- `WR_READY`, out, 1: holding register can accept a pixel.
- `RD_LINE_START`, in, 1: one-cycle pulse marking the start of a display line.
- `RD_REQ`, in, 1: display requests the next pixel.
- `RD_VALID`, out, 1: `RD_DATA` is valid.
- `RD_DATA`, out, `DATA_W`: display pixel.
- `RAM_ADDR`, out, `ADDR_W`: RAM address.
- `RAM_WE`, out, 1: RAM write enable.
- `RAM_WDATA`, out, `DATA_W`: RAM write data.
- `RAM_RDATA`, in, `DATA_W`: RAM read data, registered in the RAM, 1-cycle latency.
- `LINE_READY`, out, 1: the read bank holds a complete captured line.
- `OVERRUN`, out, 1: sticky flag; a capture pixel was dropped.
- `REPEAT_COUNT`, out, 8: saturating count of display lines that repeated the previous line.

## Operation
- **State**
  - `wr_bank` and `rd_bank`, always complementary.
  - `wr_ptr` and `rd_ptr`, each `ADDR_W-1` bits.
  - `wr_cnt`, counts pixels accepted this line.
  - Holding register: `hold_full`, `hold_addr`, `hold_data`.
  - `wr_done`.
- **Write accept**
  - A pixel is accepted when `WR_VALID & WR_READY`, where `WR_READY = !hold_full`.
  - If `wr_done=0` and `wr_cnt < LINE_LEN`:
    - load the holding register with `{wr_bank, wr_ptr}` and `WR_DATA`;
    - increment `wr_ptr` and `wr_cnt`.
  - Otherwise the pixel is accepted and discarded, and `OVERRUN` is set.
- **WR_LINE_START**
  - If `wr_done=0`: `wr_ptr` and `wr_cnt` go to 0.
  - If `wr_done=1`: ignored, and the completed line is kept.
  - If it coincides with an accept, the pixel goes to address 0.
- **Arbitration**
  - If `RD_REQ=1`: `RAM_ADDR = {rd_bank, rd_ptr}` and `RAM_WE = 0`.
  - Else if `hold_full=1`: `RAM_ADDR = hold_addr`, `RAM_WDATA = hold_data`, `RAM_WE = 1`, and `hold_full` clears.
  - Otherwise `RAM_WE = 0` and `RAM_ADDR = {rd_bank, rd_ptr}`.
  - These RAM outputs are combinational from registered state and `RD_REQ`. `RAM_WE` is forced to 0 while `RESET=1`.
- **Write completion**
  - `wr_done` sets in the cycle the holding register drains a write whose pointer is `LINE_LEN-1`.
  - It is never set on acceptance alone, so a pending write can never land in the bank being displayed.
- **Read**
  - On `RD_REQ`, if `rd_ptr < LINE_LEN`: issue a RAM read and increment `rd_ptr`.
  - Otherwise: no pointer change, and the returned data is 0 (black).
  - `RD_VALID` is `RD_REQ` delayed by 1 cycle.
  - `RD_DATA = RAM_RDATA` if the previous request was in range, else 0.
- **RD_LINE_START**
  - `rd_ptr` goes to 0.
  - If `wr_done=1` (registered value): swap
    - toggle both banks;
    - clear `wr_done`, `wr_ptr` and `wr_cnt`;
    - set `LINE_READY`, which stays 1 thereafter.
  - Else: no swap, and `REPEAT_COUNT` increments, saturating at 255.
  - If it coincides with `RD_REQ`, the read uses the post-swap bank at address 0.
  - If it coincides with the final write drain, there is no swap this line; the swap happens on the next `RD_LINE_START`.

## Timing
- Reset values:
  - `wr_bank=0`, `rd_bank=1`, all pointers and counters 0;
  - `hold_full=0`, `wr_done=0`;
  - `WR_READY=1`, `RD_VALID=0`, `RD_DATA=0`;
  - `LINE_READY=0`, `OVERRUN=0`, `REPEAT_COUNT=0`, `RAM_WE=0`.
- Read latency: request at cycle N gives `RD_VALID`/`RD_DATA` at N+1. There are no bubbles on back-to-back requests.
- Write latency: accepted at N, written to RAM at the first cycle ≥ N+1 with `RD_REQ=0`.
- Throughput: `WR_READY` stays low while `RD_REQ` is held continuously with a full holding register. Capture must tolerate this back-pressure.
- Reset mid-line: all state returns to reset values in the next cycle, and any pending held write is discarded.

## Test plan
- **Fill and swap.** Reset, write 240 pixels 0..239 with `RD_REQ=0`, wait for drain, pulse `RD_LINE_START`, then issue 240 `RD_REQ`. Required: `RD_DATA` = 0..239, each 1 cycle after its request, and `LINE_READY=1`.
- **Read priority.** Hold `RD_REQ=1` while offering `WR_VALID`. Required: `RAM_WE=0` throughout, and after one accept `WR_READY=0`. Drop `RD_REQ` for 1 cycle: `RAM_WE=1` at the held address, then `WR_READY=1`.
- **Early line start.** Pulse `RD_LINE_START` after only 100 pixels are written. Required: no swap, `REPEAT_COUNT=1`, and reads return the previous line.
- **Overrun.** Offer 245 pixels in one line. Required: the 5 extra are dropped, `OVERRUN=1`, and RAM writes occur only at pointers 0..239.
- **Past-end read.** Issue 250 `RD_REQ` on a full line. Required: requests 241..250 return `RD_DATA=0` with `RD_VALID=1`.
- **Simultaneous events.** The final drain and `RD_LINE_START` in the same cycle give no swap, and the next `RD_LINE_START` swaps. `RESET` asserted with a held write gives `RAM_WE=0` and `hold_full=0` next cycle.
